// File: rtl/jpeg_block_sequencer_if.sv
// Host/pipeline-facing signal bundle of the JPEG block sequencer.
// The host drives start/n_blocks/stall; the sequencer drives everything else.
interface jpeg_block_sequencer_if #(
    parameter int ADDR_W = 15
);
    logic              start;
    logic [12:0]       n_blocks;
    logic              stall;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [2:0]        phase;
    logic              tp1_sel;
    logic              tp2_sel;
    logic              zz_sel;
    logic              rle_en;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              busy;
    logic              done;

    modport master (
        output start, n_blocks, stall,
        input  rd_en, rd_addr, phase, tp1_sel, tp2_sel, zz_sel,
               rle_en, wr_en, wr_addr, busy, done
    );

    modport slave (
        input  start, n_blocks, stall,
        output rd_en, rd_addr, phase, tp1_sel, tp2_sel, zz_sel,
               rle_en, wr_en, wr_addr, busy, done
    );
endinterface

// File: rtl/jpeg_block_sequencer.sv
// Frame scheduler for the 8x8 JPEG block pipeline: a single frame-scoped cycle
// counter from which every strobe, address and ping-pong select is decoded.
module jpeg_block_sequencer #(
    parameter int ADDR_W     = 15,
    parameter int MAX_BLOCKS = 4096,
    parameter int TP1_OFS    = 1,
    parameter int TP2_OFS    = 10,
    parameter int ZZ_OFS     = 19,
    parameter int RLE_LAT    = 27,
    parameter int WR_LAT     = 28
) (
    input  logic                   clk,
    input  logic                   reset,
    jpeg_block_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [15:0] TP1_C = 16'(TP1_OFS);
    localparam logic [15:0] TP2_C = 16'(TP2_OFS);
    localparam logic [15:0] ZZ_C  = 16'(ZZ_OFS);
    localparam logic [15:0] RLE_C = 16'(RLE_LAT);
    localparam logic [15:0] WR_C  = 16'(WR_LAT);
    localparam logic [12:0] MAX_C = 13'(MAX_BLOCKS);

    state_t      state_q, state_d;
    logic [15:0] cyc_q, cyc_d;
    logic [12:0] nblk_q, nblk_d;
    logic        tp1_q, tp1_d;
    logic        tp2_q, tp2_d;
    logic        zz_q, zz_d;

    logic [15:0] words;
    logic [15:0] wrOfs;
    logic [12:0] nClamped;
    logic        busyNow;
    logic        busyNext;
    logic        rdActive;
    logic        wrActive;

    // High during the first half of each 16-cycle period counted from ofs.
    function automatic logic selAt(input logic [15:0] c, input logic [15:0] ofs);
        logic [15:0] diff;
        diff = c - ofs;
        return (c >= ofs) && !diff[3];
    endfunction

    assign words    = {nblk_q, 3'b000};
    assign wrOfs    = cyc_q - WR_C;
    assign nClamped = (bus.n_blocks > MAX_C) ? MAX_C : bus.n_blocks;
    assign busyNow  = (state_q == RUN) || (state_q == DRAIN);
    assign rdActive = (state_q == RUN);
    assign wrActive = busyNow && (cyc_q >= WR_C) && (wrOfs < words);

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        nblk_d   = nblk_q;
        busyNext = 1'b0;
        tp1_d    = 1'b0;
        tp2_d    = 1'b0;
        zz_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    nblk_d  = nClamped;
                    state_d = (nClamped == 13'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (!bus.stall && (cyc_q == words - 16'd1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!bus.stall && wrActive && (wrOfs == words - 16'd1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (busyNow && !bus.stall && (cyc_q != 16'hFFFF)) begin
            cyc_d = cyc_q + 16'd1;
        end

        // Selects are stored for the cycle they apply to, so a stall simply re-stores them.
        busyNext = (state_d == RUN) || (state_d == DRAIN);
        if (!busyNext) begin
            cyc_d = 16'd0;
        end
        tp1_d = busyNext && selAt(cyc_d, TP1_C);
        tp2_d = busyNext && selAt(cyc_d, TP2_C);
        zz_d  = busyNext && selAt(cyc_d, ZZ_C);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cyc_q   <= 16'd0;
            nblk_q  <= 13'd0;
            tp1_q   <= 1'b0;
            tp2_q   <= 1'b0;
            zz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            nblk_q  <= nblk_d;
            tp1_q   <= tp1_d;
            tp2_q   <= tp2_d;
            zz_q    <= zz_d;
        end
    end

    assign bus.rd_en   = rdActive && !bus.stall;
    assign bus.rd_addr = rdActive ? cyc_q[ADDR_W-1:0] : '0;
    assign bus.wr_en   = wrActive && !bus.stall;
    assign bus.wr_addr = wrActive ? wrOfs[ADDR_W-1:0] : '0;
    assign bus.phase   = busyNow ? cyc_q[2:0] : 3'd0;
    assign bus.rle_en  = busyNow && (cyc_q >= RLE_C);
    assign bus.tp1_sel = tp1_q;
    assign bus.tp2_sel = tp2_q;
    assign bus.zz_sel  = zz_q;
    assign bus.busy    = busyNow;
    assign bus.done    = (state_q == DONE);
endmodule
